lap_mem_ctrl: RTL and testbench

// - Controller for the stopwatch lap memory (external single-port sync RAM, 1-cycle read latency).
// - Captures lap times into a circular buffer on lap events and replays them oldest-first on recall.
// - Arbitrates write (lap) against read (recall) for the single RAM port.
// - Sits between the mode fsm / edge detectors and the output_sel mem input.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/lap_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_lap_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: stored time width and lap memory controller states.
// Imported by the lap memory controller and its neighbours.
package stopwatch_pkg;

  localparam int TIME_W = 12;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT
  } lapctl_state_t;

endpackage

// File: rtl/lap_mem_ctrl.sv
// Lap memory controller: circular lap buffer over a single-port sync RAM.
// Writes win over recalls; one pending slot per request type while busy.
module lap_mem_ctrl #(
  parameter int DEPTH  = 8,
  parameter int TIME_W = stopwatch_pkg::TIME_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lap_req,
  input  logic [TIME_W-1:0]          lap_time,
  input  logic                       recall_req,
  input  logic                       clear,
  input  logic [TIME_W-1:0]          mem_rdata,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [TIME_W-1:0]          mem_wdata,
  output logic [TIME_W-1:0]          lap_out,
  output logic                       lap_valid,
  output logic [$clog2(DEPTH)-1:0]   lap_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       busy
);

  import stopwatch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  lapctl_state_t     state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_idx;
  logic              pend_lap;
  logic              pend_rcl;
  logic [TIME_W-1:0] lap_buf;

  logic              pl;
  logic              pr;
  logic [TIME_W-1:0] pt;
  logic [AW-1:0]     wr_n;
  logic [CW-1:0]     cnt_n;
  logic [AW-1:0]     rdi_n;
  logic [AW-1:0]     oldest_n;
  logic [AW-1:0]     rd_addr;
  logic              do_wr;
  logic              do_rd;

  // Pointer values as they stand once the current access retires,
  // so a follow-on access can be dispatched without an idle cycle.
  always_comb begin
    pl = pend_lap;
    pt = lap_buf;
    pr = pend_rcl;
    if (lap_req && !pend_lap) begin
      pl = 1'b1;
      pt = lap_time;
    end
    if (recall_req && !pend_rcl) pr = 1'b1;

    wr_n  = wr_ptr;
    cnt_n = count;
    rdi_n = rd_idx;
    if (state == WRITE) begin
      wr_n = wr_ptr + 1'b1;
      if (count != CNT_MAX) cnt_n = count + 1'b1;
    end
    if (state == RWAIT) begin
      if ((CW'(rd_idx) + CW'(1)) == count) rdi_n = '0;
      else                                 rdi_n = rd_idx + 1'b1;
    end

    oldest_n = (cnt_n == CNT_MAX) ? wr_n : '0;
    rd_addr  = oldest_n + rdi_n;
    do_wr    = (state != READ) && pl;
    do_rd    = (state != READ) && !pl && pr && (cnt_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      pend_lap  <= 1'b0;
      pend_rcl  <= 1'b0;
      lap_buf   <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lap_out   <= '0;
      lap_valid <= 1'b0;
      lap_idx   <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      wr_ptr   <= wr_n;
      count    <= cnt_n;
      rd_idx   <= rdi_n;
      full     <= (cnt_n == CNT_MAX);
      pend_lap <= pl;
      pend_rcl <= pr;
      lap_buf  <= pt;

      if (state == RWAIT) begin
        lap_out   <= mem_rdata;
        lap_idx   <= rd_idx;
        lap_valid <= 1'b1;
      end

      unique case (1'b1)
        (state == READ): begin
          state <= RWAIT;
          busy  <= 1'b1;
        end
        do_wr: begin
          state     <= WRITE;
          busy      <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_n;
          mem_wdata <= pt;
          pend_lap  <= 1'b0;
        end
        do_rd: begin
          state    <= READ;
          busy     <= 1'b1;
          mem_re   <= 1'b1;
          mem_addr <= rd_addr;
          pend_rcl <= 1'b0;
        end
        default: begin
          // A recall against an empty buffer is dropped here.
          state    <= IDLE;
          busy     <= 1'b0;
          pend_rcl <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lap_mem_ctrl.sv
// Bench for lap_mem_ctrl: directed literal checks plus randomized traffic
// against a queue-based model of the lap buffer and a 1-cycle RAM.
module tb_lap_mem_ctrl;

  localparam int DEPTH = 8;
  localparam int TW    = 12;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lap_req = 1'b0;
  logic [TW-1:0] lap_time = '0;
  logic          recall_req = 1'b0;
  logic          clear = 1'b0;
  logic [TW-1:0] mem_rdata;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] mem_wdata;
  logic [TW-1:0] lap_out;
  logic          lap_valid;
  logic [AW-1:0] lap_idx;
  logic [AW:0]   count;
  logic          full;
  logic          busy;

  lap_mem_ctrl #(.DEPTH(DEPTH), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst),
    .lap_req(lap_req), .lap_time(lap_time),
    .recall_req(recall_req), .clear(clear),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .lap_out(lap_out), .lap_valid(lap_valid), .lap_idx(lap_idx),
    .count(count), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [TW-1:0] ram [DEPTH];
  logic [TW-1:0] ram_q = '0;
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: q holds stored laps oldest-first; the k-th lap written since
  // clear sits at address k mod DEPTH.
  int q[$];
  int nwr, rdi, m_pv, rd_val, rd_i;
  bit m_pl, m_pr;
  bit e_we, e_re, e_rw, e_valid;
  int e_addr, e_wdata, e_out, e_idx;

  task automatic m_zero();
    q.delete();
    nwr = 0; rdi = 0; m_pl = 0; m_pr = 0; m_pv = 0;
    e_we = 0; e_re = 0; e_rw = 0; e_valid = 0;
    e_addr = 0; e_wdata = 0; e_out = 0; e_idx = 0;
  endtask

  initial m_zero();

  always @(posedge clk) begin
    if (rst || clear) begin
      m_zero();
    end else begin
      bit port_free;
      port_free = !e_re;
      if (e_rw) begin
        e_out   = rd_val;
        e_idx   = rd_i;
        e_valid = 1;
        rdi     = (rdi + 1 == q.size()) ? 0 : rdi + 1;
      end
      if (e_we) begin
        if (q.size() == DEPTH) void'(q.pop_front());
        q.push_back(e_wdata);
        nwr++;
      end
      e_rw = e_re;
      e_we = 0;
      e_re = 0;
      if (lap_req && !m_pl) begin
        m_pl = 1;
        m_pv = int'(lap_time);
      end
      if (recall_req && !m_pr) m_pr = 1;
      if (port_free) begin
        if (m_pl) begin
          e_we    = 1;
          e_addr  = nwr % DEPTH;
          e_wdata = m_pv;
          m_pl    = 0;
        end else if (m_pr) begin
          m_pr = 0;
          if (q.size() > 0) begin
            e_re   = 1;
            e_addr = (nwr - q.size() + rdi) % DEPTH;
            rd_val = q[rdi];
            rd_i   = rdi;
          end
        end
      end
    end
  end

  bit started = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("mem_we", int'(mem_we), int'(e_we));
      chk("mem_re", int'(mem_re), int'(e_re));
      if (e_we || e_re) chk("mem_addr", int'(mem_addr), e_addr);
      if (e_we) chk("mem_wdata", int'(mem_wdata), e_wdata);
      chk("count", int'(count), q.size());
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("busy", int'(busy), int'(e_we || e_re || e_rw));
      chk("lap_valid", int'(lap_valid), int'(e_valid));
      chk("lap_out", int'(lap_out), e_out);
      chk("lap_idx", int'(lap_idx), e_idx);
    end
  end

  task automatic step(input bit l, input int t, input bit r,
                      input bit c, input bit rs);
    lap_req    = l;
    lap_time   = TW'(t);
    recall_req = r;
    clear      = c;
    rst        = rs;
    @(posedge clk);
    #1;
    lap_req    = 0;
    recall_req = 0;
    clear      = 0;
    rst        = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  int v3[3]  = '{12'h005, 12'h00A, 12'h0F0};
  int exp4[4] = '{12'h005, 12'h00A, 12'h0F0, 12'h005};
  int idx4[4] = '{0, 1, 2, 0};

  initial begin
    step(0, 0, 0, 0, 1);
    started = 1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(lap_valid), 0);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 3; i++) begin
      step(1, v3[i], 0, 0, 0);
      chk("lap3_we", int'(mem_we), 1);
      chk("lap3_addr", int'(mem_addr), i);
      chk("lap3_data", int'(mem_wdata), v3[i]);
      idle(2);
    end
    chk("lap3_count", int'(count), 3);
    chk("lap3_full", int'(full), 0);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("rcl_re", int'(mem_re), 1);
      idle(2);
      chk("rcl_out", int'(lap_out), exp4[i]);
      chk("rcl_idx", int'(lap_idx), idx4[i]);
      chk("rcl_valid", int'(lap_valid), 1);
      idle(1);
    end

    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      step(1, i, 0, 0, 0);
      chk("wrap_addr", int'(mem_addr), (i - 1) % DEPTH);
      chk("wrap_data", int'(mem_wdata), i);
      idle(2);
    end
    chk("wrap_full", int'(full), 1);
    chk("wrap_count", int'(count), 8);
    step(0, 0, 1, 0, 0);
    chk("wrap_raddr", int'(mem_addr), 1);
    idle(2);
    chk("wrap_out", int'(lap_out), 2);
    chk("wrap_idx", int'(lap_idx), 0);
    idle(1);

    step(0, 0, 0, 0, 1);
    step(1, 12'h111, 0, 0, 0);
    idle(2);
    step(1, 12'h222, 1, 0, 0);
    chk("both_we", int'(mem_we), 1);
    chk("both_waddr", int'(mem_addr), 1);
    idle(1);
    chk("both_re", int'(mem_re), 1);
    chk("both_raddr", int'(mem_addr), 0);
    idle(2);
    chk("both_out", int'(lap_out), 12'h111);

    step(0, 0, 1, 0, 0);
    chk("clr_re", int'(mem_re), 1);
    step(0, 0, 0, 1, 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_count", int'(count), 0);
    chk("clr_valid", int'(lap_valid), 0);
    step(0, 0, 1, 0, 0);
    chk("clr_no_re", int'(mem_re), 0);
    idle(1);
    chk("clr_no_re2", int'(mem_re), 0);

    step(0, 0, 1, 0, 0);
    chk("empty_re", int'(mem_re), 0);
    chk("empty_busy", int'(busy), 0);
    step(1, 12'h333, 0, 0, 0);
    chk("rstw_we", int'(mem_we), 1);
    step(0, 0, 0, 0, 1);
    chk("rstw_we0", int'(mem_we), 0);
    chk("rstw_addr", int'(mem_addr), 0);
    chk("rstw_wdata", int'(mem_wdata), 0);
    chk("rstw_count", int'(count), 0);
    chk("rstw_busy", int'(busy), 0);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 30, int'($urandom_range(0, 4095)),
           $urandom_range(0, 99) < 35, $urandom_range(0, 199) < 3,
           $urandom_range(0, 999) < 3);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
